// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus multi-cycle core: opcodes, FSM states
// and the bit positions of the {ZF, CF, SF} flag vector.
package aeolus_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_LDO = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_INV = 4'h9;
  localparam logic [3:0] OP_CLR = 4'hA;
  localparam logic [3:0] OP_LSH = 4'hB;
  localparam logic [3:0] OP_RSH = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_JNZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 0;

endpackage

// File: rtl/aeolus_alu.sv
// Combinational ALU for the accumulator opcodes (ADD..RSH): produces the new
// ACC value and the updated flag vector; flags not touched by an op pass through.
module aeolus_alu
  import aeolus_pkg::*;
#(
  parameter int ACC_WIDTH = 8
) (
  input  logic [3:0]           i_op,
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [2:0]           i_flags,
  output logic [ACC_WIDTH-1:0] o_result,
  output logic [2:0]           o_flags,
  output logic                 o_acc_wr
);

  logic [ACC_WIDTH:0] w_sum;

  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign o_acc_wr = (i_op >= OP_ADD) && (i_op <= OP_RSH);

  always_comb begin
    o_result = '0;
    o_flags  = i_flags;
    case (i_op)
      OP_ADD: begin
        o_result        = w_sum[ACC_WIDTH-1:0];
        o_flags[FLAG_C] = w_sum[ACC_WIDTH];
      end
      OP_SUB: begin
        o_result        = i_a - i_b;
        o_flags[FLAG_C] = (i_a < i_b);
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_INV: o_result = ~i_a;
      OP_CLR: o_result = '0;
      OP_LSH: begin
        o_result        = i_acc << 1;
        o_flags[FLAG_S] = i_acc[ACC_WIDTH-1];
      end
      OP_RSH: begin
        o_result        = i_acc >> 1;
        o_flags[FLAG_S] = i_acc[0];
      end
      default: o_result = '0;
    endcase
    if (o_acc_wr) o_flags[FLAG_Z] = (o_result == '0);
  end

endmodule

// File: rtl/aeolus_multicycle_core.sv
// Aeolus multi-cycle CPU: FETCH/DECODE/EXECUTE sequencer over a synchronous
// instruction ROM, with A/B/ACC/O registers, jumps, halt and Z/C/S flags.
module aeolus_multicycle_core
  import aeolus_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int ACC_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int INSTR_WIDTH = 4 + ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [2*IN_WIDTH-1:0]  switches,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [ACC_WIDTH-1:0]   cpu_out,
  output logic [2:0]             flags,
  output logic                   halted
);

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [IN_WIDTH-1:0]    r_a;
  logic [IN_WIDTH-1:0]    r_b;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   r_o;
  logic [2:0]             r_flags;
  logic                   r_halted;

  logic [3:0]             w_op;
  logic [ADDR_WIDTH-1:0]  w_operand;
  logic [ADDR_WIDTH-1:0]  w_pc_inc;
  logic [ACC_WIDTH-1:0]   w_a_ext;
  logic [ACC_WIDTH-1:0]   w_b_ext;
  logic [ACC_WIDTH-1:0]   w_alu_result;
  logic [2:0]             w_alu_flags;
  logic                   w_alu_wr;

  assign w_op      = r_ir[INSTR_WIDTH-1 -: 4];
  assign w_operand = r_ir[ADDR_WIDTH-1:0];
  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_a_ext   = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, r_a};
  assign w_b_ext   = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, r_b};

  assign rom_addr = r_pc;
  assign cpu_out  = r_o;
  assign flags    = r_flags;
  assign halted   = r_halted;

  aeolus_alu #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_alu (
    .i_op    (w_op),
    .i_a     (w_a_ext),
    .i_b     (w_b_ext),
    .i_acc   (r_acc),
    .i_flags (r_flags),
    .o_result(w_alu_result),
    .o_flags (w_alu_flags),
    .o_acc_wr(w_alu_wr)
  );

  // Reset is the first branch so it cancels whatever EXECUTE would commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_o      <= '0;
      r_flags  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (run) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir    <= rom_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_pc    <= w_pc_inc;
          if (w_alu_wr) begin
            r_acc   <= w_alu_result;
            r_flags <= w_alu_flags;
          end
          case (w_op)
            OP_LDA: r_a <= switches[2*IN_WIDTH-1 -: IN_WIDTH];
            OP_LDB: r_b <= switches[IN_WIDTH-1:0];
            OP_LDO: r_o <= r_acc;
            OP_JMP: r_pc <= w_operand;
            OP_JNZ: if (r_acc != '0) r_pc <= w_operand;
            OP_HLT: begin
              r_pc     <= r_pc;
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
